mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 868, giving clocks per serial bit.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 8, a power of two of at least 2.
REQ-003 The block SHALL expose parameter BASE_ADDR, default 32'h0000_1000, as the word-aligned register base.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port WE, input, 1 bit, the data-bus store strobe from the processor memory stage.
REQ-007 The block SHALL have port A, input, 32 bits, the data-bus byte address.
REQ-008 The block SHALL have port WD, input, 32 bits, the data-bus store data.
REQ-009 The block SHALL have port RD, output, 32 bits, the combinational register read data.
REQ-010 The block SHALL have port tx, output, 1 bit, the serial line, idle high.

Function
REQ-011 Register TXDATA at BASE_ADDR+0: a WE=1 write while the FIFO is not full SHALL push WD[7:0] at that edge; WD[31:8] SHALL be ignored.
REQ-012 A TXDATA write while the FIFO is full SHALL be dropped and SHALL set the sticky overflow flag.
REQ-013 Register STATUS at BASE_ADDR+4 SHALL read {28'b0, overflow, busy, empty, full} in bits [3:0].
REQ-014 A STATUS write with WD[3]=1 SHALL clear overflow; other STATUS bits SHALL be read-only.
REQ-015 A write that both clears overflow and overflows in the same cycle SHALL leave overflow set.
REQ-016 RD SHALL be combinational from A and current state; TXDATA and unmapped addresses SHALL read 0.
REQ-017 Address decode SHALL compare A[31:2] only; writes to unmapped addresses SHALL have no effect.
REQ-018 The transmitter FSM SHALL have states IDLE, START, DATA and STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START at the next edge.
REQ-020 tx SHALL go low in the first cycle after the edge that pushed into an empty FIFO with the FSM in IDLE.
REQ-021 START, each of 8 DATA bits (LSB first) and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles.
REQ-022 A baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; a bit index SHALL count 0..7 in DATA.
REQ-023 At the end of STOP the FSM SHALL pop the next byte and enter START when non-empty, else enter IDLE, adding no idle cycle between frames.
REQ-024 A push and pop in the same cycle SHALL be legal, and SHALL be legal even when the FIFO is full, leaving the count unchanged.
REQ-025 busy SHALL be 1 in any state other than IDLE.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL derive from an occupancy count of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-027 Reset SHALL asynchronously force FSM=IDLE, tx=1, baud counter=0, bit index=0, FIFO empty, overflow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with tx=1, and queued bytes SHALL be discarded.
REQ-029 After reset, STATUS SHALL read 32'h0000_0002.

Structure
REQ-030 Package rx32_mmio_pkg SHALL hold the FSM state enum and the register offset constants TXDATA_OFS=0 and STATUS_OFS=4.
REQ-031 The FIFO SHALL be a sub-module sync_fifo, parameterised by width and depth, with push, pop, full, empty, wdata and rdata ports.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Reset then read STATUS -> RD=32'h2, tx=1.
REQ-033 Write 32'hFFFF_FFA5 to TXDATA -> 40-cycle frame on tx: 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, then IDLE with STATUS=32'h2.
REQ-034 Write 6 bytes back-to-back (0x01..0x06) -> first is popped at once, next 4 fill the FIFO (full=1), sixth sets overflow; STATUS=32'hD; frames 0x01..0x05 are sent contiguously.
REQ-035 Write STATUS with WD=32'h8 after overflow -> overflow=0; full/empty/busy unchanged.
REQ-036 Assert reset at cycle 10 of the 0x5A frame -> tx=1 in the same cycle, STATUS=32'h2, no further frames are sent.
REQ-037 Write to BASE_ADDR+8 and read BASE_ADDR+0 -> no push, RD=0.

Source files
------------

// File: rtl/rx32_mmio_pkg.sv
// Shared types and register map for the MMIO UART transmitter.
// State encoding and byte offsets of the programmer-visible registers.
package rx32_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  // Packs the STATUS flags into the low nibble of the read word.
  function automatic logic [31:0] status_word(
    input logic ovf,
    input logic busy,
    input logic empty,
    input logic full
  );
    return {28'b0, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and empty fall-through.
// A push and pop together on an empty FIFO hands wdata straight out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign full  = (r_count == DEPTH_C);
  assign empty = (r_count == '0);

  // Empty push+pop passes through without touching storage.
  assign w_bypass = empty && push && pop;
  assign w_wr     = push && (!full || pop) && !w_bypass;
  assign w_rd     = pop && !empty;

  assign rdata = empty ? wdata : r_mem[r_rd_ptr];

  // Storage array; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy count; simultaneous store and read leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, byte FIFO,
// and an 8N1 serialiser with back-to-back frames.
module mmio_uart_tx
  import rx32_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  tx_state_e      r_state;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_ovf;

  logic           w_sel_tx;
  logic           w_sel_st;
  logic           w_wr_tx;
  logic           w_wr_st;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_rdata;
  logic           w_avail;
  logic           w_pop;
  logic           w_baud_end;
  logic           w_busy;
  logic           w_ovf_set;
  logic           w_unused;

  assign w_sel_tx = (A[31:2] == TXDATA_ADDR[31:2]);
  assign w_sel_st = (A[31:2] == STATUS_ADDR[31:2]);
  assign w_wr_tx  = WE && w_sel_tx;
  assign w_wr_st  = WE && w_sel_st;

  assign w_unused = ^{WD[31:8], A[1:0]};

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_busy     = (r_state != ST_IDLE);

  // A byte is available if queued, or arriving this cycle on the bus.
  assign w_avail = !w_empty || w_wr_tx;

  // Overflow only when the store cannot be absorbed by a same-cycle pop.
  assign w_ovf_set = w_wr_tx && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .wdata (WD[7:0]),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  // Pop when idle, or at the last stop-bit cycle for gapless frames.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      ST_IDLE: w_pop = w_avail;
      ST_STOP: w_pop = w_baud_end && w_avail;
      default: w_pop = 1'b0;
    endcase
  end

  // Register read mux; TXDATA and holes read as zero.
  always_comb begin
    RD = 32'h0;
    if (w_sel_st) begin
      RD = status_word(r_ovf, w_busy, w_empty, w_full);
    end
  end

  // Sticky overflow; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_wr_st && WD[3]) begin
      r_ovf <= 1'b0;
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_state <= ST_START;
            r_shift <= w_rdata;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state <= ST_START;
              r_shift <= w_rdata;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks/bit and a 4-deep FIFO.
// Each scenario task checks tx and RD against hand-derived values.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] TXA  = BASE;
  localparam logic [31:0] STA  = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] WD = 32'h0;
  logic [31:0] RD;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1;
    A  = a;
    WD = d;
    tick();
    WE = 1'b0;
  endtask

  // Expected line level c cycles into a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int s;
    s = c / CPB;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    A = STA;
    tick();
    tick();
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL reset_status_in_reset got=%h want=%h", RD, 32'h2);
    end
    n_vec++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tx_in_reset got=%b want=1", tx);
    end
    reset = 1'b0;
    tick();
    tick();
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL reset_status got=%h want=%h", RD, 32'h2);
    end
    n_vec++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tx got=%b want=1", tx);
    end
  endtask

  task automatic test_unmapped();
    wr(BASE + 32'd8, 32'h0000_00AA);
    wr(32'h0000_2000, 32'h0000_0055);
    A = STA;
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL unmapped_no_push got=%h want=%h", RD, 32'h2);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tx !== 1'b1) begin
        n_err++;
        $display("FAIL unmapped_tx_idle cyc=%0d got=%b want=1", i, tx);
      end
      tick();
    end
    A = TXA;
    #1;
    n_vec++;
    if (RD !== 32'h0) begin
      n_err++;
      $display("FAIL read_txdata got=%h want=0", RD);
    end
    A = BASE + 32'd8;
    #1;
    n_vec++;
    if (RD !== 32'h0) begin
      n_err++;
      $display("FAIL read_hole got=%h want=0", RD);
    end
    A = BASE + 32'd5;
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL read_status_bytealias got=%h want=%h", RD, 32'h2);
    end
  endtask

  task automatic test_frame();
    logic [7:0] b;
    b = 8'hA5;
    wr(TXA, 32'hFFFF_FFA5);
    for (int k = 0; k < 10 * CPB; k++) begin
      n_vec++;
      if (tx !== exp_tx(b, k)) begin
        n_err++;
        $display("FAIL frame_a5 cyc=%0d got=%b want=%b",
                 k, tx, exp_tx(b, k));
      end
      tick();
    end
    A = STA;
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL frame_end_status got=%h want=%h", RD, 32'h2);
    end
    n_vec++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end_tx got=%b want=1", tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int f;
    int c;
    logic e;
    WE = 1'b1;
    A  = TXA;
    WD = 32'h01;
    for (int k = 0; k <= 50 * CPB; k++) begin
      tick();
      if (k < 5) begin
        WD = 32'(k + 2);
      end else begin
        WE = 1'b0;
        A  = STA;
      end
      #1;
      f = k / (10 * CPB);
      c = k % (10 * CPB);
      b = 8'(f + 1);
      e = (f >= 5) ? 1'b1 : exp_tx(b, c);
      n_vec++;
      if (tx !== e) begin
        n_err++;
        $display("FAIL b2b_tx cyc=%0d got=%b want=%b", k, tx, e);
      end
      if (k == 5) begin
        n_vec++;
        if (RD !== 32'hD) begin
          n_err++;
          $display("FAIL b2b_status_full_ovf got=%h want=%h", RD, 32'hD);
        end
      end
    end
    n_vec++;
    if (RD !== 32'hA) begin
      n_err++;
      $display("FAIL b2b_end_status got=%h want=%h", RD, 32'hA);
    end
  endtask

  task automatic test_ovf_clear();
    wr(STA, 32'h8);
    A = STA;
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL ovf_clear_idle got=%h want=%h", RD, 32'h2);
    end
    for (int i = 0; i < 6; i++) begin
      wr(TXA, 32'(8'h11 + i));
    end
    A = STA;
    #1;
    n_vec++;
    if (RD !== 32'hD) begin
      n_err++;
      $display("FAIL ovf_set got=%h want=%h", RD, 32'hD);
    end
    wr(STA, 32'h8);
    A = STA;
    #1;
    n_vec++;
    if (RD !== 32'h5) begin
      n_err++;
      $display("FAIL ovf_clear_busy got=%h want=%h", RD, 32'h5);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL ovf_reset_status got=%h want=%h", RD, 32'h2);
    end
  endtask

  task automatic test_reset_mid();
    wr(TXA, 32'h5A);
    wr(TXA, 32'h33);
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL mid_bit0 got=%b want=0", tx);
    end
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    A = STA;
    #1;
    n_vec++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_tx got=%b want=1", tx);
    end
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL mid_reset_status got=%h want=%h", RD, 32'h2);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15 * CPB; i++) begin
      tick();
      n_vec++;
      if (tx !== 1'b1) begin
        n_err++;
        $display("FAIL mid_no_resume cyc=%0d got=%b want=1", i, tx);
      end
    end
    #1;
    n_vec++;
    if (RD !== 32'h2) begin
      n_err++;
      $display("FAIL mid_final_status got=%h want=%h", RD, 32'h2);
    end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_frame();
    test_back_to_back();
    test_ovf_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
